fb_branch_predict_unit: RTL

- Parametrised successor to the static-prediction control hazard unit.
- Predicts conditional branches at IF using a table of 2-bit saturating counters (BHT), or static backward-taken/forward-not-taken (BTFN) when configured.
- Resolves every control-transfer instruction at EX against full RV32 branch semantics, then drives redirect/flush and trains the table.
- Keeps a misprediction counter for performance checks.

---
 rtl/fb_branch_predict_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// fb_branch_predict_unit
//
// Branch prediction and resolution for a word-addressed RV32-style pipeline.
//   IF side : predicts conditional branches with a table of 2-bit saturating
//             counters (PRED_MODE=1) or static backward-taken/forward-not-taken
//             (PRED_MODE=0). JAL is always predicted taken; JALR never is.
//   EX side : resolves B-type/JAL/JALR, raises redirect on a misprediction,
//             supplies the corrected fetch PC and trains the counter table.
//   Counts every redirect in mispredict_cnt (wraps at 2^32).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   if_pc/if_is_branch/if_is_jal/if_imm   IF instruction info
//   pred_taken, pred_pc   prediction and next fetch PC
//   ex_valid/ex_branch/ex_jal/ex_jalr/ex_funct3/ex_rs1/ex_rs2/ex_pc/ex_imm/
//   ex_pred_taken         EX instruction info and the prediction it carried
//   redirect, redirect_pc misprediction flush request and corrected PC
//   mispredict_cnt        redirects since reset
// ---------------------------------------------------------------------------
module fb_branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned PRED_MODE   = 1,
  parameter int unsigned PC_INC      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_is_branch,
  input  logic            if_is_jal,
  input  logic [XLEN-1:0] if_imm,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_pc,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_cnt
);

  localparam int unsigned Idx     = (BHT_ENTRIES < 2) ? 1 : $clog2(BHT_ENTRIES);
  localparam int unsigned Entries = 1 << Idx;
  localparam bit          Dynamic = (PRED_MODE != 0);
  localparam logic [XLEN-1:0] PcStep = XLEN'(PC_INC);

  logic [1:0]      bht_q [Entries];
  logic [1:0]      if_ctr;
  logic [1:0]      ex_ctr;
  logic [1:0]      ex_ctr_d;
  logic [Idx-1:0]  if_idx;
  logic [Idx-1:0]  ex_idx;
  logic            br_cond;
  logic            bht_upd;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] jalr_sum;
  logic [31:0]     mispredict_cnt_q;

  assign if_idx = if_pc[Idx-1:0];
  assign ex_idx = ex_pc[Idx-1:0];
  assign if_ctr = bht_q[if_idx];
  assign ex_ctr = bht_q[ex_idx];

  // ---------------------------------------------------------------------------
  // IF prediction
  // ---------------------------------------------------------------------------
  always_comb begin
    pred_taken = 1'b0;
    if (if_is_jal) begin
      pred_taken = 1'b1;
    end else if (if_is_branch) begin
      // Static mode: negative offset means a backward branch, predict taken.
      pred_taken = Dynamic ? if_ctr[1] : if_imm[XLEN-1];
    end
    pred_pc = pred_taken ? (if_pc + if_imm) : (if_pc + PcStep);
  end

  // ---------------------------------------------------------------------------
  // EX resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    case (ex_funct3)
      3'b000:  br_cond = (ex_rs1 == ex_rs2);
      3'b001:  br_cond = (ex_rs1 != ex_rs2);
      3'b100:  br_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  br_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  br_cond = (ex_rs1 <  ex_rs2);
      3'b111:  br_cond = (ex_rs1 >= ex_rs2);
      default: br_cond = 1'b0;  // 010/011 are not branches; treat as not taken
    endcase
  end

  assign jalr_sum = ex_rs1 + ex_imm;

  always_comb begin
    redirect  = 1'b0;
    ex_target = ex_pc + ex_imm;
    if (ex_valid) begin
      // Priority jalr > jal > branch when decode flags overlap.
      if (ex_jalr) begin
        redirect  = 1'b1;
        ex_target = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (ex_jal) begin
        redirect  = !ex_pred_taken;
        ex_target = ex_pc + ex_imm;
      end else if (ex_branch) begin
        redirect  = (br_cond != ex_pred_taken);
        ex_target = br_cond ? (ex_pc + ex_imm) : (ex_pc + PcStep);
      end
    end
    redirect_pc = redirect ? ex_target : (ex_pc + PcStep);
  end

  // ---------------------------------------------------------------------------
  // Counter table training
  // ---------------------------------------------------------------------------
  assign bht_upd = Dynamic && ex_valid && ex_branch;

  always_comb begin
    if (br_cond) begin
      ex_ctr_d = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'b01;
    end else begin
      ex_ctr_d = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'b01;
    end
  end

  // Lookup reads bht_q directly, so a same-cycle update to the same index is
  // not visible to IF until the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bht_upd) begin
      bht_q[ex_idx] <= ex_ctr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Misprediction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt_q <= '0;
    end else if (redirect) begin
      mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt = mispredict_cnt_q;

endmodule
